// File: rtl/window_event_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_event_tracker_pkg
// Description : Timing constants shared by the window tracker and its counter.
// Revision    : 1.0 - initial release
// ============================================================================
package window_event_tracker_pkg;

    localparam int SAMPLE_RATE    = 200000;
    localparam int WINDOW_SAMPLES = 200000;
    localparam int TS_WIDTH       = 18;
    // Must cover WINDOW_SAMPLES events so the downstream counter never wraps.
    localparam int COUNT_WIDTH    = 19;

endpackage
`default_nettype wire

// File: rtl/window_event_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : window_event_tracker_if
// Description : Sample/event inputs and window pulse outputs of the tracker.
// Revision    : 1.0 - initial release
// ============================================================================
interface window_event_tracker_if #(
    parameter int AW = 6
) ();

    logic          sample_en;
    logic          evt_in;
    logic          up;
    logic          down;
    logic [AW:0]   occupancy;
    logic          overflow;

    modport master (
        output sample_en,
        output evt_in,
        input  up,
        input  down,
        input  occupancy,
        input  overflow
    );

    modport slave (
        input  sample_en,
        input  evt_in,
        output up,
        output down,
        output occupancy,
        output overflow
    );

endinterface
`default_nettype wire

// File: rtl/window_event_tracker_ts_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ts_fifo
// Description : Show-ahead synchronous FIFO holding event timestamps.
// Revision    : 1.0 - initial release
// ============================================================================
module ts_fifo #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 64
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    input  wire logic                          wr_en,
    input  wire logic [DATA_WIDTH-1:0]         wr_data,
    input  wire logic                          rd_en,
    output logic      [DATA_WIDTH-1:0]         rd_data,
    output logic      [$clog2(DEPTH):0]        count,
    output logic                               full,
    output logic                               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  w_do_wr;
    logic                  w_do_rd;

    // A write into a full FIFO is accepted when the head leaves in the same cycle.
    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);

    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/window_event_tracker.sv
`default_nettype none
// ============================================================================
// Module      : window_event_tracker
// Description : Emits up on event entry and down exactly WINDOW samples later.
// Revision    : 1.0 - initial release
// ============================================================================
module window_event_tracker
    import window_event_tracker_pkg::*;
#(
    parameter int WINDOW   = WINDOW_SAMPLES,
    parameter int TS_WIDTH = window_event_tracker_pkg::TS_WIDTH,
    parameter int DEPTH    = 64,
    parameter int AW       = 6
) (
    input  wire logic                clk,
    input  wire logic                reset,
    window_event_tracker_if.slave    bus
);

    localparam logic [TS_WIDTH-1:0] c_ts_last = TS_WIDTH'(WINDOW - 1);

    logic [TS_WIDTH-1:0] r_ts;
    logic                r_evt_prev;
    logic                r_up;
    logic                r_down;
    logic                r_overflow;

    logic [TS_WIDTH-1:0] w_head;
    logic [AW:0]         w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_rise;
    logic                w_expire;
    logic                w_push;
    logic                w_drop;

    // All decisions in a sample cycle compare against the pre-increment timestamp.
    assign w_rise   = bus.sample_en & bus.evt_in & ~r_evt_prev;
    assign w_expire = bus.sample_en & ~w_empty & (w_head == r_ts);
    assign w_push   = w_rise & (~w_full | w_expire);
    assign w_drop   = w_rise & w_full & ~w_expire;

    ts_fifo #(
        .DATA_WIDTH (TS_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ts_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_push),
        .wr_data (r_ts),
        .rd_en   (w_expire),
        .rd_data (w_head),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts       <= '0;
            r_evt_prev <= 1'b0;
            r_up       <= 1'b0;
            r_down     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_up   <= w_push;
            r_down <= w_expire;
            if (bus.sample_en) begin
                r_evt_prev <= bus.evt_in;
                r_ts       <= (r_ts == c_ts_last) ? '0 : r_ts + 1'b1;
            end
            // Sticky: once an event is lost the downstream count is short until reset.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.up        = r_up;
    assign bus.down      = r_down;
    assign bus.occupancy = w_count;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire
